// File: rtl/ad9518_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad9518_spi_pkg
// Purpose  : Shared types and word-layout constants for the AD9518 3-wire
//            SPI master.
// Revision : 1.0 - initial release
// ============================================================================
package ad9518_spi_pkg;

   // Word sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4,
      GAP   = 3'd5
   } state_t;

   // Command word layout
   localparam int WORD_BITS  = 24;
   localparam int INSTR_BITS = 16;
   localparam int RW_BIT     = 23;
   localparam int DATA_BITS  = 8;

   // Width of the bit counter (counts 0..WORD_BITS-1)
   localparam int BIT_CNT_W  = 5;

endpackage
`default_nettype wire

// File: rtl/ad9518_spi_master_tick.sv
`default_nettype none
// ============================================================================
// Module   : ad9518_spi_tick
// Purpose  : SCLK half-period timer. Emits a one-cycle tick every CLK_DIV
//            cycles; restarting aligns the first tick CLK_DIV cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module ad9518_spi_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_restart,
   output logic o_tick
);

   localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Free-running modulo-CLK_DIV counter, zeroed on reset or restart
   always_ff @(posedge CLK) begin
      if (RST || i_restart) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ad9518_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : ad9518_spi_master
// Purpose  : Shifts one 24-bit AD9518 command word out over the 3-wire SPI,
//            turns SDIO around for read instructions and captures the byte,
//            then pulses CONFIG_END and enforces a CS_N high gap.
// Revision : 1.0 - initial release
// ============================================================================
module ad9518_spi_master #(
   parameter int CLK_DIV        = 4,
   parameter int CS_HIGH_CYCLES = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CONFIG_EN,
   input  logic [23:0] CONFIG_DATA,
   output logic        CONFIG_END,
   output logic        BUSY,
   output logic        SPI_CS_N,
   output logic        SPI_SCLK,
   output logic        SPI_SDO,
   output logic        SPI_SDO_OE,
   input  logic        SPI_SDI,
   output logic [7:0]  RD_DATA,
   output logic        RD_VALID
);

   import ad9518_spi_pkg::*;

   localparam logic [BIT_CNT_W-1:0] c_LAST_BIT       = BIT_CNT_W'(WORD_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] c_FIRST_RD_BIT   = BIT_CNT_W'(INSTR_BITS);
   localparam logic [BIT_CNT_W-1:0] c_LAST_INSTR_BIT = BIT_CNT_W'(INSTR_BITS - 1);
   localparam int                   c_GAP_W          = $clog2(CS_HIGH_CYCLES + 1);
   localparam logic [c_GAP_W-1:0]   c_GAP_LAST       = c_GAP_W'(CS_HIGH_CYCLES - 1);

   state_t                 r_state;
   logic [WORD_BITS-2:0]   r_shift;     // bits still to be sent after the one on SDO
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_is_read;
   logic [DATA_BITS-1:0]   r_rd_shift;
   logic [c_GAP_W-1:0]     r_gap_cnt;
   logic                   r_armed;
   logic                   w_tick;
   logic                   w_start;

   // A word starts only from IDLE and only once per CONFIG_EN low period
   assign w_start = (r_state == IDLE) && CONFIG_EN && r_armed;

   ad9518_spi_tick #(
      .CLK_DIV   (CLK_DIV)
   ) u_tick (
      .CLK       (CLK),
      .RST       (RST),
      .i_restart (w_start),
      .o_tick    (w_tick)
   );

   // Word sequencer: drives the SPI pins and the handshake outputs
   always_ff @(posedge CLK) begin
      CONFIG_END <= 1'b0;
      RD_VALID   <= 1'b0;
      if (RST) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_is_read  <= 1'b0;
         r_rd_shift <= '0;
         r_gap_cnt  <= '0;
         r_armed    <= 1'b1;
         BUSY       <= 1'b0;
         SPI_CS_N   <= 1'b1;
         SPI_SCLK   <= 1'b0;
         SPI_SDO    <= 1'b0;
         SPI_SDO_OE <= 1'b0;
         RD_DATA    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_shift    <= CONFIG_DATA[WORD_BITS-2:0];
                  r_is_read  <= CONFIG_DATA[RW_BIT];
                  r_bit_cnt  <= '0;
                  SPI_SDO    <= CONFIG_DATA[WORD_BITS-1];
                  SPI_SDO_OE <= 1'b1;
                  SPI_CS_N   <= 1'b0;
                  BUSY       <= 1'b1;
                  r_state    <= SETUP;
               end
            end

            SETUP: begin
               if (w_tick) begin
                  r_state <= SHIFT;
               end
            end

            SHIFT: begin
               if (w_tick) begin
                  if (!SPI_SCLK) begin
                     // Rising edge: the device samples SDO, we sample SDI on
                     // the data phase of a read
                     SPI_SCLK <= 1'b1;
                     if (r_is_read && (r_bit_cnt >= c_FIRST_RD_BIT)) begin
                        r_rd_shift <= {r_rd_shift[DATA_BITS-2:0], SPI_SDI};
                     end
                  end else begin
                     // Falling edge: advance to the next bit
                     SPI_SCLK <= 1'b0;
                     if (r_bit_cnt == c_LAST_BIT) begin
                        r_state <= HOLD;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        SPI_SDO   <= r_shift[WORD_BITS-2];
                        r_shift   <= {r_shift[WORD_BITS-3:0], 1'b0};
                        // Hand SDIO to the device once the instruction is out
                        if (r_is_read && (r_bit_cnt == c_LAST_INSTR_BIT)) begin
                           SPI_SDO_OE <= 1'b0;
                        end
                     end
                  end
               end
            end

            HOLD: begin
               if (w_tick) begin
                  SPI_CS_N   <= 1'b1;
                  SPI_SDO_OE <= 1'b0;
                  SPI_SDO    <= 1'b0;
                  CONFIG_END <= 1'b1;
                  if (r_is_read) begin
                     RD_DATA  <= r_rd_shift;
                     RD_VALID <= 1'b1;
                  end
                  r_state <= DONE;
               end
            end

            DONE: begin
               // The CONFIG_END cycle is the first cycle of the CS high gap
               r_gap_cnt <= c_GAP_W'(1);
               r_state   <= GAP;
            end

            GAP: begin
               if (r_gap_cnt >= c_GAP_LAST) begin
                  BUSY    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase

         // Re-arm whenever CONFIG_EN is seen low; disarm on completion so a
         // held-high CONFIG_EN cannot retrigger
         if (!CONFIG_EN) begin
            r_armed <= 1'b1;
         end else if (CONFIG_END) begin
            r_armed <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ad9518_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9518_spi_master
// Purpose  : Self-checking bench for ad9518_spi_master with a pin-level
//            device model and directed plus randomized command words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9518_spi_master;

   localparam int CLK_DIV        = 4;
   localparam int CS_HIGH_CYCLES = 8;
   localparam int CS_LOW_CYCLES  = 50 * CLK_DIV;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CONFIG_EN;
   logic [23:0] CONFIG_DATA;
   logic        CONFIG_END;
   logic        BUSY;
   logic        SPI_CS_N;
   logic        SPI_SCLK;
   logic        SPI_SDO;
   logic        SPI_SDO_OE;
   logic        spi_sdi = 1'b0;
   logic [7:0]  RD_DATA;
   logic        RD_VALID;

   int n_vec  = 0;
   int n_fail = 0;

   ad9518_spi_master #(
      .CLK_DIV        (CLK_DIV),
      .CS_HIGH_CYCLES (CS_HIGH_CYCLES)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .CONFIG_EN   (CONFIG_EN),
      .CONFIG_DATA (CONFIG_DATA),
      .CONFIG_END  (CONFIG_END),
      .BUSY        (BUSY),
      .SPI_CS_N    (SPI_CS_N),
      .SPI_SCLK    (SPI_SCLK),
      .SPI_SDO     (SPI_SDO),
      .SPI_SDO_OE  (SPI_SDO_OE),
      .SPI_SDI     (spi_sdi),
      .RD_DATA     (RD_DATA),
      .RD_VALID    (RD_VALID)
   );

   always #5 CLK = ~CLK;

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Device model: watches the pins once per cycle (outputs only move on
   // the rising CLK edge), records each word, drives the read byte.
   // ---------------------------------------------------------------------
   logic [7:0]  rd_byte = 8'h00;
   logic [23:0] mon_words [$];
   int          mon_gaps  [$];
   int          mon_end_cnt = 0;
   int          mon_rdv_cnt = 0;
   int          last_rises = 0, last_cs_low = 0, last_oe_rise = 0;
   logic        last_oe_sclk = 1'b0, last_end_at_rise = 1'b0;
   logic [23:0] cur_cap = '0;
   int          cur_rises = 0, cur_cs_low = 0, cur_oe_rise = -1, cs_high_run = 0;
   logic        cur_oe_sclk = 1'b0;
   logic        p_cs = 1'b1, p_sclk = 1'b0, have_prev = 1'b0;

   always @(negedge CLK) begin
      if (RST) begin
         p_cs      = 1'b1;
         p_sclk    = 1'b0;
         have_prev = 1'b0;
         cs_high_run = 0;
      end else begin
         if (p_cs && !SPI_CS_N) begin
            cur_cap = '0; cur_rises = 0; cur_cs_low = 0;
            cur_oe_rise = -1; cur_oe_sclk = 1'b0; spi_sdi = 1'b0;
            if (have_prev) mon_gaps.push_back(cs_high_run);
         end
         if (!SPI_CS_N) begin
            cur_cs_low++;
            if (!p_sclk && SPI_SCLK) begin
               cur_cap = {cur_cap[22:0], SPI_SDO};
               cur_rises++;
            end
            if (p_sclk && !SPI_SCLK && cur_rises >= 16 && cur_rises < 24)
               spi_sdi = rd_byte[3'(23 - cur_rises)];
            if (!SPI_SDO_OE && cur_oe_rise < 0) begin
               cur_oe_rise = cur_rises;
               cur_oe_sclk = SPI_SCLK;
            end
            cs_high_run = 0;
         end else begin
            cs_high_run++;
         end
         if (!p_cs && SPI_CS_N) begin
            mon_words.push_back(cur_cap);
            last_rises = cur_rises; last_cs_low = cur_cs_low;
            last_oe_rise = cur_oe_rise; last_oe_sclk = cur_oe_sclk;
            last_end_at_rise = CONFIG_END;
            have_prev = 1'b1;
         end
         if (CONFIG_END) mon_end_cnt++;
         if (RD_VALID)   mon_rdv_cnt++;
         p_cs   = SPI_CS_N;
         p_sclk = SPI_SCLK;
      end
   end

   // ---------------------------------------------------------------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK); #1;
         if (CONFIG_END === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One pulsed word; when chg is set the inputs are disturbed mid-word
   task automatic run_word(input logic [23:0] w, input logic [7:0] rdb, input bit chg);
      int n0, e0, v0, cnt;
      bit ok;
      n0 = mon_words.size(); e0 = mon_end_cnt; v0 = mon_rdv_cnt;
      rd_byte     = rdb;
      CONFIG_DATA = w;
      CONFIG_EN   = 1'b1;
      @(posedge CLK); #1;
      CONFIG_EN   = 1'b0;
      chk("e0_cs_n", 32'(SPI_CS_N), 32'd0);
      chk("e0_busy", 32'(BUSY), 32'd1);
      chk("e0_sdo",  32'(SPI_SDO), 32'(w[23]));
      chk("e0_oe",   32'(SPI_SDO_OE), 32'd1);
      if (chg) begin
         repeat (50) @(posedge CLK); #1;
         CONFIG_DATA = 24'hFFFFFF;
         CONFIG_EN   = 1'b1;
         @(posedge CLK); #1;
         CONFIG_EN   = 1'b0;
      end
      wait_end(CS_LOW_CYCLES + 50, ok);
      chk("end_seen", 32'(ok), 32'd1);
      chk("done_cs_n", 32'(SPI_CS_N), 32'd1);
      chk("done_busy", 32'(BUSY), 32'd1);
      chk("rd_valid", 32'(RD_VALID), 32'(w[23]));
      if (w[23]) chk("rd_data", 32'(RD_DATA), 32'(rdb));
      @(posedge CLK); #1;
      chk("end_pulse", 32'(CONFIG_END), 32'd0);
      chk("word_cnt", 32'(mon_words.size()), 32'(n0 + 1));
      if (mon_words.size() > n0) begin
         if (w[23]) chk("instr", 32'(mon_words[n0][23:8]), 32'(w[23:8]));
         else       chk("word",  32'(mon_words[n0]), 32'(w));
      end
      chk("rises", 32'(last_rises), 32'd24);
      chk("cs_low", 32'(last_cs_low), 32'(CS_LOW_CYCLES));
      chk("end_at_cs_rise", 32'(last_end_at_rise), 32'd1);
      if (w[23]) begin
         chk("oe_off_rise", 32'(last_oe_rise), 32'd16);
         chk("oe_off_sclk", 32'(last_oe_sclk), 32'd0);
      end else begin
         chk("oe_kept", 32'(last_oe_rise), 32'hFFFFFFFF);
      end
      cnt = 1;
      while (BUSY === 1'b1 && cnt < 50) begin
         @(posedge CLK); #1;
         cnt++;
      end
      chk("gap_len", 32'(cnt >= CS_HIGH_CYCLES && cnt <= CS_HIGH_CYCLES + 2), 32'd1);
      repeat (20) @(posedge CLK); #1;
      chk("one_word", 32'(mon_words.size()), 32'(n0 + 1));
      chk("end_cnt", 32'(mon_end_cnt - e0), 32'd1);
      chk("rdv_cnt", 32'(mon_rdv_cnt - v0), 32'(w[23]));
   endtask

   // ---------------------------------------------------------------------
   logic [23:0] seq [3] = '{24'h000018, 24'h000100, 24'h000210};

   initial begin
      int  n0, e0, g0, rises;
      bit  ok, prev;
      logic [23:0] w;
      logic [7:0]  b;

      CONFIG_EN = 1'b0; CONFIG_DATA = '0; RST = 1'b1;
      repeat (4) @(posedge CLK); #1;
      chk("rst_cs_n",   32'(SPI_CS_N), 32'd1);
      chk("rst_sclk",   32'(SPI_SCLK), 32'd0);
      chk("rst_sdo",    32'(SPI_SDO), 32'd0);
      chk("rst_oe",     32'(SPI_SDO_OE), 32'd0);
      chk("rst_busy",   32'(BUSY), 32'd0);
      chk("rst_end",    32'(CONFIG_END), 32'd0);
      chk("rst_rdv",    32'(RD_VALID), 32'd0);
      chk("rst_rddata", 32'(RD_DATA), 32'd0);
      RST = 1'b0;
      repeat (2) @(posedge CLK); #1;

      // Single write, then single read
      run_word(24'h000018, 8'h00, 1'b0);
      run_word(24'h801100, 8'hA5, 1'b0);

      // Sequencer style: CONFIG_EN held, dropped one cycle after each end
      n0 = mon_words.size(); e0 = mon_end_cnt; g0 = mon_gaps.size();
      CONFIG_DATA = seq[0];
      CONFIG_EN   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_end(CS_LOW_CYCLES + CS_HIGH_CYCLES + 50, ok);
         chk("seq_end", 32'(ok), 32'd1);
         CONFIG_EN = 1'b0;
         @(posedge CLK); #1;
         if (k < 2) begin
            CONFIG_DATA = seq[k + 1];
            CONFIG_EN   = 1'b1;
         end
      end
      repeat (300) @(posedge CLK); #1;
      chk("seq_cnt", 32'(mon_words.size()), 32'(n0 + 3));
      chk("seq_ends", 32'(mon_end_cnt - e0), 32'd3);
      for (int k = 0; k < 3; k++)
         if (mon_words.size() > n0 + k) chk("seq_word", 32'(mon_words[n0 + k]), 32'(seq[k]));
      for (int k = g0; k < mon_gaps.size(); k++)
         chk("seq_gap_min", 32'(mon_gaps[k] >= CS_HIGH_CYCLES), 32'd1);

      // CONFIG_EN stuck high: one word only
      n0 = mon_words.size(); e0 = mon_end_cnt;
      CONFIG_DATA = 24'h000210;
      CONFIG_EN   = 1'b1;
      repeat (1000) @(posedge CLK); #1;
      CONFIG_EN   = 1'b0;
      repeat (20) @(posedge CLK); #1;
      chk("held_cnt", 32'(mon_words.size()), 32'(n0 + 1));
      chk("held_ends", 32'(mon_end_cnt - e0), 32'd1);
      if (mon_words.size() > n0) chk("held_word", 32'(mon_words[n0]), 32'h000210);

      // Reset during the 10th bit of a read
      e0 = mon_end_cnt;
      rd_byte = 8'h3C; CONFIG_DATA = 24'h80ABCD; CONFIG_EN = 1'b1;
      @(posedge CLK); #1;
      CONFIG_EN = 1'b0;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 200 && rises < 10; i++) begin
         @(posedge CLK); #1;
         if (SPI_SCLK && !prev) rises++;
         prev = SPI_SCLK;
      end
      chk("rst_mid_reached", 32'(rises), 32'd10);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("rstm_cs_n",   32'(SPI_CS_N), 32'd1);
      chk("rstm_sclk",   32'(SPI_SCLK), 32'd0);
      chk("rstm_busy",   32'(BUSY), 32'd0);
      chk("rstm_end",    32'(CONFIG_END), 32'd0);
      chk("rstm_oe",     32'(SPI_SDO_OE), 32'd0);
      chk("rstm_rddata", 32'(RD_DATA), 32'd0);
      RST = 1'b0;
      repeat (300) @(posedge CLK); #1;
      chk("rstm_no_end", 32'(mon_end_cnt - e0), 32'd0);
      chk("rstm_idle",   32'(BUSY), 32'd0);
      run_word(24'h4A5A5A, 8'h00, 1'b0);

      // Inputs disturbed mid-word
      run_word(24'h001807, 8'h00, 1'b1);

      // Randomized words, alternating write and read
      for (int k = 0; k < 6; k++) begin
         w     = 24'($urandom);
         w[23] = k[0];
         b     = 8'($urandom);
         run_word(w, b, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
